// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default sizing, and the 8-bit carry-lookahead slice helpers used by
// the subtract stage.
package div_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam int CNT_W_DEFAULT = 6;
    // Restoring division retires one quotient bit per trial subtraction,
    // so a WIDTH-bit quotient takes WIDTH * ITERS_PER_BIT iterations.
    localparam int ITERS_PER_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Group generate/propagate of an 8-bit slice, returned as {G, P}.
    function automatic logic [1:0] cla8_gp(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] g;
        logic [7:0] p;
        logic       grp_g;
        logic       run_p;
        g     = a & b;
        p     = a ^ b;
        grp_g = 1'b0;
        run_p = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            grp_g = grp_g | (g[i] & run_p);
            run_p = run_p & p[i];
        end
        return {grp_g, run_p};
    endfunction

    // Sum of an 8-bit slice; every internal carry is a flat lookahead term
    // of the bit generates/propagates and the slice carry-in.
    function automatic logic [7:0] cla8_sum(input logic [7:0] a, input logic [7:0] b,
                                            input logic cin);
        logic [7:0] g;
        logic [7:0] p;
        logic [7:0] sum;
        logic       acc;
        logic       run_p;
        g = a & b;
        p = a ^ b;
        for (int i = 0; i < 8; i++) begin
            acc   = 1'b0;
            run_p = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                acc   = acc | (g[j] & run_p);
                run_p = run_p & p[j];
            end
            acc    = acc | (cin & run_p);
            sum[i] = p[i] ^ acc;
        end
        return sum;
    endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Combinational trial-subtract stage: (WIDTH+1)-bit minuend minus a
// WIDTH-bit divisor, computed as minuend + ~divisor + 1 with chained
// 8-bit carry-lookahead slices. o_carry=1 means no borrow.
module div_sub_stage
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   i_minuend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_carry
);

    localparam int N_SLICE = WIDTH / 8;

    logic [WIDTH-1:0]   w_b_inv;
    logic [N_SLICE-1:0] w_grp_g;
    logic [N_SLICE-1:0] w_grp_p;
    logic [N_SLICE:0]   w_carry;

    assign w_b_inv = ~i_divisor;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLICE; gi++) begin : g_slice
            assign {w_grp_g[gi], w_grp_p[gi]} = cla8_gp(i_minuend[gi*8 +: 8], w_b_inv[gi*8 +: 8]);
            assign o_diff[gi*8 +: 8] = cla8_sum(i_minuend[gi*8 +: 8], w_b_inv[gi*8 +: 8], w_carry[gi]);
        end
    endgenerate

    // Slice-level carry chain from the group G/P terms; carry-in 1 completes the negation.
    always_comb begin
        w_carry[0] = 1'b1;
        for (int k = 0; k < N_SLICE; k++) begin
            w_carry[k+1] = w_grp_g[k] | (w_grp_p[k] & w_carry[k]);
        end
    end

    // Top bit: the divisor is zero-extended there, so its inverted bit is 1
    // (g = minuend bit, p = ~minuend bit). The difference MSB is not needed:
    // whenever there is no borrow the true difference is below the divisor.
    assign o_carry = i_minuend[WIDTH] | w_carry[N_SLICE];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider. Operands are reduced to magnitudes
// at capture, one quotient bit is resolved per cycle, and signs are applied
// when the result is registered. Truncating division: the remainder takes
// the dividend's sign.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int               N_ITER    = WIDTH * ITERS_PER_BIT;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

    div_state_e       r_state;
    div_state_e       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_r;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_div0;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_remainder;
    logic             r_exception;
    logic             r_ready;

    logic             w_iterate;
    logic             w_finish;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_trial;
    logic             w_no_borrow;
    logic [WIDTH-1:0] w_q_signed;
    logic [WIDTH-1:0] w_r_signed;

    // Magnitudes; the most negative value maps onto its unsigned magnitude.
    assign w_b_zero   = (operand_B == '0);
    assign w_abs_a    = operand_A[WIDTH-1] ? (~operand_A + WIDTH'(1)) : operand_A;
    assign w_abs_b    = operand_B[WIDTH-1] ? (~operand_B + WIDTH'(1)) : operand_B;
    assign w_shifted  = {r_r, r_q[WIDTH-1]};
    assign w_q_signed = r_sign_q ? (~r_q + WIDTH'(1)) : r_q;
    assign w_r_signed = r_sign_r ? (~r_r + WIDTH'(1)) : r_r;

    div_sub_stage #(
        .WIDTH(WIDTH)
    ) u_sub (
        .i_minuend(w_shifted),
        .i_divisor(r_d),
        .o_diff   (w_trial),
        .o_carry  (w_no_borrow)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a start pulse overrides whatever is in flight.
    always_comb begin
        w_next_state = r_state;
        if (ctrl_div) begin
            w_next_state = w_b_zero ? DONE : BUSY;
        end else begin
            case (r_state)
                IDLE:    w_next_state = IDLE;
                BUSY:    w_next_state = (r_cnt == LAST_ITER) ? DONE : BUSY;
                DONE:    w_next_state = IDLE;
                default: w_next_state = IDLE;
            endcase
        end
    end

    // FSM outputs: iterate only while busy and not being restarted.
    always_comb begin
        w_iterate = (r_state == BUSY) && !ctrl_div;
        w_finish  = (r_state == DONE);
    end

    // Datapath: capture operands on start, otherwise one restoring step per busy cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt    <= '0;
            r_q      <= '0;
            r_d      <= '0;
            r_r      <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_div0   <= 1'b0;
        end else if (ctrl_div) begin
            r_cnt    <= '0;
            r_q      <= w_abs_a;
            r_d      <= w_abs_b;
            r_r      <= '0;
            r_sign_q <= operand_A[WIDTH-1] ^ operand_B[WIDTH-1];
            r_sign_r <= operand_A[WIDTH-1];
            r_div0   <= w_b_zero;
        end else if (w_iterate) begin
            r_cnt <= r_cnt + CNT_W'(1);
            r_r   <= w_no_borrow ? w_trial : w_shifted[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_no_borrow};
        end
    end

    // Result registers: loaded with sign fix-up in the DONE cycle, held otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_result    <= '0;
            r_remainder <= '0;
            r_exception <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_ready <= w_finish;
            if (w_finish) begin
                r_result    <= r_div0 ? '0 : w_q_signed;
                r_remainder <= r_div0 ? '0 : w_r_signed;
                r_exception <= r_div0;
            end
        end
    end

    assign data_result    = r_result;
    assign data_remainder = r_remainder;
    assign data_exception = r_exception;
    assign data_resultRDY = r_ready;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every ready strobe.
module tb_seq_divider;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         ctrl_div = 1'b0;
    logic [W-1:0] operand_A = '0;
    logic [W-1:0] operand_B = '0;
    logic [W-1:0] data_result;
    logic [W-1:0] data_remainder;
    logic         data_exception;
    logic         data_resultRDY;

    seq_divider #(
        .WIDTH(W),
        .CNT_W(6)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .ctrl_div      (ctrl_div),
        .operand_A     (operand_A),
        .operand_B     (operand_B),
        .data_result   (data_result),
        .data_remainder(data_remainder),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         exc;
        int           start;
        int           lat;
        int           id;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   op_id  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every ready strobe must match the oldest outstanding expectation.
    exp_t m_e;
    always @(negedge clock) begin
        if (reset_n && data_resultRDY) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: strobe at cycle %0d with no operation outstanding", cyc);
            end else begin
                m_e = sb.pop_front();
                check($sformatf("op%0d_result", m_e.id), data_result, m_e.q);
                check($sformatf("op%0d_remainder", m_e.id), data_remainder, m_e.r);
                check($sformatf("op%0d_exception", m_e.id), W'(data_exception), W'(m_e.exc));
                check($sformatf("op%0d_latency", m_e.id), W'(cyc - m_e.start), W'(m_e.lat));
                $display("op%0d: q=0x%08h r=0x%08h exc=%0d latency=%0d", m_e.id,
                         data_result, data_remainder, data_exception, cyc - m_e.start);
            end
        end
    end

    // Issue one start pulse; optionally record the expected completion.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] q, input logic [W-1:0] r,
                            input logic exc, input bit push);
        exp_t e;
        @(posedge clock);
        #1;
        ctrl_div  = 1'b1;
        operand_A = a;
        operand_B = b;
        @(posedge clock);
        #1;
        ctrl_div = 1'b0;
        op_id++;
        if (push) begin
            e.q     = q;
            e.r     = r;
            e.exc   = exc;
            e.start = cyc;
            e.lat   = (b == '0) ? 1 : W + 1;
            e.id    = op_id;
            sb.push_back(e);
        end
    endtask

    // Bounded wait for all outstanding expectations to be consumed.
    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: %0d results still outstanding after %0d cycles", sb.size(), n);
            sb.delete();
        end
        repeat (2) @(posedge clock);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_result"}, data_result, '0);
        check({tag, "_remainder"}, data_remainder, '0);
        check({tag, "_exception"}, W'(data_exception), '0);
        check({tag, "_ready"}, W'(data_resultRDY), '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1 check_zero_outputs("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Basic and sign combinations
        start_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);             wait_idle();
        start_op(-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 1'b1);       wait_idle();
        start_op(32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0, 1'b1);         wait_idle();
        start_op(-32'sd100, -32'sd7, 32'd14, -32'sd2, 1'b0, 1'b1);       wait_idle();

        // Divide by zero, then a normal operation clears the exception
        start_op(32'd5, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1);                wait_idle();
        start_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);                wait_idle();

        // Boundaries
        start_op(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1); wait_idle();
        start_op(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1);         wait_idle();
        start_op(32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 1'b1);                        wait_idle();

        // Restart: first operation aborted ten cycles in, only the second completes
        start_op(32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (8) @(posedge clock);
        start_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b1);
        wait_idle();
        repeat (40) @(posedge clock);
        start_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);             wait_idle();

        // Asynchronous reset mid-operation: outputs clear at once, no strobe follows
        start_op(32'd200, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (15) @(posedge clock);
        #3 reset_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (45) @(posedge clock);
        start_op(32'd21, 32'd4, 32'd5, 32'd1, 1'b0, 1'b1);               wait_idle();

        repeat (5) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
